// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants, FSM encoding and field sequencing helpers for mdio_master
package mdio_pkg;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST_BITS  = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;
  typedef enum logic [3:0] {IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, DONE} state_t;
  function automatic state_t next_field(state_t s);
    return s == PRE ? ST : s == ST ? OP : s == OP ? PHYAD : s == PHYAD ? REGAD :
           s == REGAD ? TA : s == TA ? DATA : s == DATA ? DONE : IDLE;
  endfunction
  function automatic logic [4:0] field_last(state_t s);
    return (s == PHYAD || s == REGAD) ? 5'd4 : s == DATA ? 5'd15 : 5'd1;
  endfunction
endpackage

// File: rtl/mdio_mdc_gen.sv
// mdio_mdc_gen: MDC divider; one bit period is 2*CLK_DIV clk, low half first.
//  clk, rstn (async, active low), soft_reset (sync), en (frame bits in progress)
//  mdc: registered management clock, idles low
//  fall_tick: last cycle of a bit, next edge starts a new bit (MDC falls)
//  sample_tick: last cycle of the MDC high phase
module mdio_mdc_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic soft_reset,
  input  logic en,
  output logic mdc,
  output logic fall_tick,
  output logic sample_tick
);
  localparam int W = $clog2(2 * CLK_DIV);
  localparam logic [W-1:0] HI_START = W'(CLK_DIV - 1);
  localparam logic [W-1:0] LAST = W'(2 * CLK_DIV - 1);
  logic [W-1:0] cnt;
  if (CLK_DIV < 4) begin : g_bad_div
    $error("mdio_mdc_gen: CLK_DIV must be >= 4");
  end
  assign fall_tick = en && cnt == LAST;
  assign sample_tick = fall_tick;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (soft_reset || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      mdc <= cnt == HI_START ? 1'b1 : cnt == LAST ? 1'b0 : mdc;
    end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO station-management master (MDC generation, frame tx, read capture).
//  Host side: cmd_valid/cmd_ready/cmd_write/cmd_phyad/cmd_regad/cmd_wdata in,
//             rsp_valid (1-cycle pulse)/rsp_rdata/busy out.
//  Pad side:  MDC, MDIO_out, MDIO_oe out; MDIO_in in (asynchronous, 2-FF synchronised).
//  rstn: async active-low reset; soft_reset: sync abort (keeps last rsp_rdata).
//  Optional MDIO_MASTER_PRE_SUP_EN adds input pre_sup: 1 skips the 32-bit preamble.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               soft_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [PHYAD_W-1:0] cmd_phyad,
  input  logic [REGAD_W-1:0] cmd_regad,
  input  logic [DATA_W-1:0]  cmd_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               busy,
  output logic               MDC,
  output logic               MDIO_out,
  output logic               MDIO_oe,
`ifdef MDIO_MASTER_PRE_SUP_EN
  input  logic               pre_sup,
`endif
  input  logic               MDIO_in
);
  localparam int FRAME_W = 6 + PHYAD_W + REGAD_W + DATA_W;
  state_t state, nxt;
  logic [4:0] cnt;
  logic [FRAME_W-1:0] sr, frame;
  logic [DATA_W-1:0] rx;
  logic wr, sy1, sy2, en, fall_tick, sample_tick, skip_pre;
`ifdef MDIO_MASTER_PRE_SUP_EN
  assign skip_pre = pre_sup;
`else
  assign skip_pre = 1'b0;
`endif
  assign en = state != IDLE && state != DONE;
  assign busy = ~cmd_ready;
  assign nxt = cnt == 5'd0 ? next_field(state) : state;
  // Everything after the preamble goes out of one shift register; read frames
  // park ones in the TA/DATA slots since the bus is released there anyway.
  assign frame = {ST_BITS, cmd_write ? OP_WRITE : OP_READ, cmd_phyad, cmd_regad,
                  cmd_write ? {TA_WRITE, cmd_wdata} : {(DATA_W + 2){1'b1}}};
  mdio_mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk(clk),
    .rstn(rstn),
    .soft_reset(soft_reset),
    .en(en),
    .mdc(MDC),
    .fall_tick(fall_tick),
    .sample_tick(sample_tick)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      rx <= '0;
      wr <= 1'b0;
      sy1 <= 1'b0;
      sy2 <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      MDIO_out <= 1'b1;
      MDIO_oe <= 1'b0;
    end else if (soft_reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      rx <= '0;
      wr <= 1'b0;
      sy1 <= 1'b0;
      sy2 <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      MDIO_out <= 1'b1;
      MDIO_oe <= 1'b0;
    end else begin
      sy1 <= MDIO_in;
      sy2 <= sy1;
      rsp_valid <= 1'b0;
      if (state == DATA && !wr && sample_tick) rx <= {rx[DATA_W-2:0], sy2};
      if (state == IDLE && cmd_valid) begin
        state <= skip_pre ? ST : PRE;
        cnt <= skip_pre ? field_last(ST) : 5'(PRE_LEN - 1);
        sr <= skip_pre ? frame << 1 : frame;
        MDIO_out <= skip_pre ? frame[FRAME_W-1] : 1'b1;
        MDIO_oe <= 1'b1;
        wr <= cmd_write;
        cmd_ready <= 1'b0;
      end else if (state == DONE) begin
        state <= IDLE;
        cmd_ready <= 1'b1;
      end else if (fall_tick) begin
        state <= nxt;
        cnt <= cnt == 5'd0 ? field_last(nxt) : cnt - 5'd1;
        rsp_valid <= nxt == DONE;
        if (nxt == DONE) rsp_rdata <= wr ? '0 : {rx[DATA_W-2:0], sy2};
        MDIO_out <= nxt == DONE || nxt == PRE || sr[FRAME_W-1];
        MDIO_oe <= nxt != DONE && !(!wr && (nxt == TA || nxt == DATA));
        if (nxt != PRE) sr <= sr << 1;
      end
    end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed checks of mdio_master against a small MDIO slave model
module tb_mdio_master;
  logic clk = 1'b0, rstn = 1'b0, soft_reset = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0;
  logic pre_sup_v = 1'b0;
  logic [4:0] cmd_phyad = '0, cmd_regad = '0;
  logic [15:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, busy, mdc, mdio_out, mdio_oe;
  logic [15:0] rsp_rdata;
  logic mdio_in = 1'b1;
  logic mdc_q = 1'b0;
  logic seen = 1'b0;
  logic [63:0] cap = '0, oeh = '0;
  logic [15:0] rd_val = '0;
  logic [15:0] regs [32] = '{2: 16'h0141, default: 16'h0000};
  int bi = 0, base = 48, n_acc = 0, acc0 = 0, n_tests = 0, n_fail = 0, lat = 0, guard = 0;

  always #5 clk = ~clk;

  mdio_master dut (
    .clk(clk),
    .rstn(rstn),
    .soft_reset(soft_reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_phyad(cmd_phyad),
    .cmd_regad(cmd_regad),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy(busy),
    .MDC(mdc),
    .MDIO_out(mdio_out),
    .MDIO_oe(mdio_oe),
`ifdef MDIO_MASTER_PRE_SUP_EN
    .pre_sup(pre_sup_v),
`endif
    .MDIO_in(mdio_in)
  );

  // Slave model: captures MDIO_out/MDIO_oe on MDC rising edges, stores write
  // frames in regs and drives read data for the 16 data bits.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready && rstn && !soft_reset) begin
      n_acc++;
      bi = 0;
      base = pre_sup_v ? 16 : 48;
    end
    if (mdc && !mdc_q) begin
      cap = {cap[62:0], mdio_out};
      oeh = {oeh[62:0], mdio_oe};
      if (bi == base && cap[14:13] == 2'b10) rd_val = regs[cap[7:3]];
      if (bi >= base && bi < base + 16) mdio_in = rd_val[15 - (bi - base)];
      if (bi == base + 15 && cap[29:28] == 2'b01) regs[cap[22:18]] = cap[15:0];
      bi++;
    end
    mdc_q = mdc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [4:0] ph, input logic [4:0] rg,
                       input logic [15:0] d, input logic sup);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_phyad = ph;
    cmd_regad = rg;
    cmd_wdata = d;
    pre_sup_v = sup;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    pre_sup_v = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!rsp_valid && l < 2000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mdc", mdc, 0);
    check("rst_out", mdio_out, 1);
    check("rst_oe", mdio_oe, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;

    issue(1'b1, 5'h01, 5'h00, 16'h1200, 1'b0);
    check("wr_busy", busy, 1);
    check("wr_ready", cmd_ready, 0);
    wait_rsp(lat);
    check("wr_lat", lat, 513);
    check("wr_bits", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1200});
    check("wr_oe", oeh, {64{1'b1}});
    check("wr_rdata", rsp_rdata, 0);
    check("wr_done_oe", mdio_oe, 0);
    check("wr_done_mdc", mdc, 0);
    check("wr_done_busy", busy, 1);
    check("wr_model", regs[0], 16'h1200);
    @(posedge clk);
    #1;
    check("wr_idle_ready", cmd_ready, 1);
    check("wr_idle_busy", busy, 0);
    check("wr_rsp_pulse", rsp_valid, 0);

    issue(1'b0, 5'h03, 5'h02, 16'hFFFF, 1'b0);
    wait_rsp(lat);
    check("rd_lat", lat, 513);
    check("rd_rdata", rsp_rdata, 16'h0141);
    check("rd_hdr", cap >> 18, {18'h0, 32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, 5'h02});
    check("rd_op", cap[29:28], 2'b10);
    check("rd_oe", oeh, {{46{1'b1}}, 18'h0});

    acc0 = n_acc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_phyad = 5'h01;
    cmd_regad = 5'h04;
    cmd_wdata = 16'hA5A5;
    @(posedge clk);
    #1;
    cmd_phyad = 5'h02;
    cmd_regad = 5'h05;
    cmd_wdata = 16'h5A5A;
    wait_rsp(lat);
    check("hold_lat", lat, 513);
    check("hold_one_acc", 64'(n_acc - acc0), 1);
    check("hold_bits", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'hA5A5});
    @(posedge clk);
    #1;
    check("hold_ready_back", cmd_ready, 1);
    @(posedge clk);
    #1;
    check("hold_second_acc", 64'(n_acc - acc0), 2);
    check("hold_busy2", busy, 1);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("hold_lat2", lat, 513);
    check("hold_bits2", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h02, 5'h05, 2'b10, 16'h5A5A});
    check("hold_reg4", regs[4], 16'hA5A5);
    check("hold_reg5", regs[5], 16'h5A5A);

    issue(1'b1, 5'h03, 5'h09, 16'hBEEF, 1'b0);
    wait_rsp(lat);
    check("loop_wr_model", regs[9], 16'hBEEF);
    issue(1'b0, 5'h03, 5'h09, 16'h0000, 1'b0);
    wait_rsp(lat);
    check("loop_rd_lat", lat, 513);
    check("loop_rd_data", rsp_rdata, 16'hBEEF);

    issue(1'b0, 5'h03, 5'h02, 16'h0000, 1'b0);
    guard = 0;
    while (bi < 53 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("sr_reached_data", guard < 2000, 1);
    @(posedge clk);
    #1;
    soft_reset = 1'b1;
    @(posedge clk);
    #1;
    soft_reset = 1'b0;
    check("sr_mdc", mdc, 0);
    check("sr_oe", mdio_oe, 0);
    check("sr_out", mdio_out, 1);
    check("sr_busy", busy, 0);
    check("sr_ready", cmd_ready, 1);
    check("sr_rdata_kept", rsp_rdata, 16'hBEEF);
    seen = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (rsp_valid || mdc) seen = 1'b1;
    end
    check("sr_no_rsp", seen, 0);

    issue(1'b1, 5'h01, 5'h07, 16'h1234, 1'b0);
    repeat (60) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_mdc", mdc, 0);
    check("ar_oe", mdio_oe, 0);
    check("ar_busy", busy, 0);
    check("ar_ready", cmd_ready, 1);
    check("ar_rdata", rsp_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (600) @(negedge clk);
    check("ar_no_write", regs[7], 0);

`ifdef MDIO_MASTER_PRE_SUP_EN
    issue(1'b0, 5'h03, 5'h02, 16'h0000, 1'b1);
    wait_rsp(lat);
    check("ps_lat", lat, 257);
    check("ps_rdata", rsp_rdata, 16'h0141);
    check("ps_start", cap[31:30], 2'b01);
    check("ps_hdr", cap[31:18], {2'b01, 2'b10, 5'h03, 5'h02});
    check("ps_oe", oeh[31:0], {{14{1'b1}}, 18'h0});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
